rb_window_agu: RTL and testbench



---
 rtl/rb_agu_pkg.sv | 32 +++
 rtl/rb_window_agu_raster.sv | 50 +++++
 rtl/rb_window_agu.sv | 215 +++++++++++++++++++++
 tb/tb_rb_window_agu.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rb_agu_pkg.sv
// rb_agu_pkg: shared types, default geometry and helpers for the row-buffer
// window address generator.
//   agu_state_e : frame-level FSM state
//   DEF_*       : default geometry used as parameter defaults by the top
//   CW/LW/BAW/EAW : column, line, BRAM-address and external-address widths
//                   for the default geometry
//   line_inc    : line index increment modulo the line-buffer depth
package rb_agu_pkg;

    localparam int unsigned DEF_MAX_WIDTH  = 1024;
    localparam int unsigned DEF_MAX_HEIGHT = 1024;
    localparam int unsigned DEF_RB_COUNT   = 4;
    localparam int unsigned DEF_KERNEL     = 3;

    localparam int unsigned CW  = $clog2(DEF_MAX_WIDTH);
    localparam int unsigned LW  = $clog2(DEF_RB_COUNT);
    localparam int unsigned BAW = LW + CW;
    localparam int unsigned EAW = $clog2(DEF_MAX_WIDTH * DEF_MAX_HEIGHT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } agu_state_e;

    // Wrapping increment; keeps line indices as a modulo counter, no divider.
    function automatic int unsigned line_inc(input int unsigned line,
                                             input int unsigned count);
        return (line + 1 >= count) ? 0 : line + 1;
    endfunction

endpackage

// File: rtl/rb_window_agu_raster.sv
// rb_raster_ctr: raster-order (col,row) counter with runtime line width.
//   clk, rst      : clock, synchronous active-low reset
//   clr_i         : synchronous clear to (0,0)
//   adv_i         : advance one position
//   width_i       : active line width W (>=1)
//   row_max_i     : index of the last row
//   col_o, row_o  : current position
//   col_last_o    : col == W-1
//   last_o        : final position of the frame
module rb_raster_ctr #(
    parameter int unsigned CW = 10,
    parameter int unsigned RW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          adv_i,
    input  logic [CW:0]   width_i,
    input  logic [RW-1:0] row_max_i,
    output logic [CW-1:0] col_o,
    output logic [RW-1:0] row_o,
    output logic          col_last_o,
    output logic          last_o
);

    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic          row_last;

    assign col_last_o = ({1'b0, col_q} == width_i - (CW+1)'(1));
    assign row_last   = (row_q == row_max_i);
    assign last_o     = col_last_o && row_last;
    assign col_o      = col_q;
    assign row_o      = row_q;

    always_ff @(posedge clk) begin
        if (!rst || clr_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if (adv_i) begin
            if (col_last_o) begin
                col_q <= '0;
                row_q <= row_last ? '0 : row_q + RW'(1);
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/rb_window_agu.sv
// rb_window_agu: row-buffer address generator for a KERNEL-row sliding window
// over a circular buffer of RB_COUNT BRAM lines, runtime frame size.
//   start/abort, cfg_width/cfg_height : frame control and geometry
//   busy, done, cfg_err               : frame status
//   ext_addr/ext_valid/ext_ready      : external pixel fetch (linear address)
//   wr_addr/wr_en                     : BRAM write port {line, col}
//   rd_col/rd_lines/rd_valid/rd_ready/rd_last : window read side
module rb_window_agu
    import rb_agu_pkg::*;
#(
    parameter int unsigned MAX_WIDTH    = DEF_MAX_WIDTH,
    parameter int unsigned MAX_HEIGHT   = DEF_MAX_HEIGHT,
    parameter int unsigned RB_COUNT     = DEF_RB_COUNT,
    parameter int unsigned KERNEL       = DEF_KERNEL,
    parameter int unsigned STALL_CYCLES = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  abort,
    input  logic [$clog2(MAX_WIDTH):0]            cfg_width,
    input  logic [$clog2(MAX_HEIGHT):0]           cfg_height,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  cfg_err,
    output logic [$clog2(MAX_WIDTH*MAX_HEIGHT)-1:0] ext_addr,
    output logic                                  ext_valid,
    input  logic                                  ext_ready,
    output logic [$clog2(RB_COUNT)+$clog2(MAX_WIDTH)-1:0] wr_addr,
    output logic                                  wr_en,
    output logic [$clog2(MAX_WIDTH)-1:0]          rd_col,
    output logic [KERNEL*$clog2(RB_COUNT)-1:0]    rd_lines,
    output logic                                  rd_valid,
    input  logic                                  rd_ready,
    output logic                                  rd_last
);

    localparam int unsigned C_W = $clog2(MAX_WIDTH);
    localparam int unsigned H_W = $clog2(MAX_HEIGHT) + 1;
    localparam int unsigned L_W = $clog2(RB_COUNT);
    localparam int unsigned B_W = L_W + C_W;
    localparam int unsigned E_W = $clog2(MAX_WIDTH * MAX_HEIGHT);
    localparam int unsigned P_W = B_W + 1;

    agu_state_e state_q, state_d;

    logic [C_W:0]   w_q;
    logic [H_W-1:0] h_q;
    logic           cfg_err_q;
    logic           fetch_done_q;
    logic [E_W-1:0] addr_q;
    logic [L_W-1:0] fline_q, rline_q;
    logic [H_W-1:0] rows_wr_q, rows_rd_q;

    logic           run, cfg_legal, start_ok, clr;
    logic           credit, ext_hs, rd_hs;
    logic [C_W-1:0] fcol, rcol;
    logic [H_W-1:0] frow, rrow;
    logic           fcol_last, f_last, rcol_last, r_last;
    logic [P_W-1:0] wr_pay, wr_p;
    logic           wr_v;

    assign cfg_legal = (cfg_width != '0) && (cfg_width <= (C_W+1)'(MAX_WIDTH)) &&
                       (cfg_height >= H_W'(KERNEL)) && (cfg_height <= H_W'(MAX_HEIGHT));
    assign start_ok  = (state_q == ST_IDLE) && start && !abort && cfg_legal;
    assign clr       = start_ok || abort;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start_ok) state_d = ST_RUN;
            ST_RUN: begin
                if (abort)                  state_d = ST_IDLE;
                else if (rd_hs && rd_last)  state_d = ST_FIN;
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        run  = (state_q == ST_RUN);
        busy = run;
        done = (state_q == ST_FIN);
    end

    // ---------------- frame registers ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            w_q       <= '0;
            h_q       <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= (state_q == ST_IDLE) && start && !abort && !cfg_legal;
            if (start_ok) begin
                w_q <= cfg_width;
                h_q <= cfg_height;
            end
        end
    end
    assign cfg_err = cfg_err_q;

    // ---------------- fetch side ----------------
    // Row fy may be fetched once rows_read + RB_COUNT > fy, i.e. its line is free.
    assign credit    = ({2'b0, frow} < {2'b0, rows_rd_q} + (H_W+2)'(RB_COUNT));
    assign ext_valid = run && !fetch_done_q && credit;
    assign ext_hs    = ext_valid && ext_ready;
    assign ext_addr  = addr_q;

    rb_raster_ctr #(.CW(C_W), .RW(H_W)) u_fetch_ctr (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr),
        .adv_i      (ext_hs),
        .width_i    (w_q),
        .row_max_i  (h_q - H_W'(1)),
        .col_o      (fcol),
        .row_o      (frow),
        .col_last_o (fcol_last),
        .last_o     (f_last)
    );

    // Raster order makes y*W+x a plain running count of handshakes.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            addr_q       <= '0;
            fetch_done_q <= 1'b0;
            fline_q      <= '0;
        end else if (ext_hs) begin
            addr_q <= addr_q + E_W'(1);
            if (f_last)    fetch_done_q <= 1'b1;
            if (fcol_last) fline_q <= L_W'(line_inc(32'(fline_q), RB_COUNT));
        end
    end

    // ---------------- write pipeline ----------------
    assign wr_pay = {fline_q, fcol, fcol_last};

    if (STALL_CYCLES == 0) begin : g_nostall
        assign wr_v = ext_hs;
        assign wr_p = wr_pay;
    end else begin : g_stall
        logic [STALL_CYCLES-1:0] v_q;
        logic [P_W-1:0]          p_q [STALL_CYCLES];

        always_ff @(posedge clk) begin
            if (!rst || abort) begin
                v_q <= '0;
                for (int unsigned i = 0; i < STALL_CYCLES; i++) p_q[i] <= '0;
            end else begin
                v_q[0] <= ext_hs;
                p_q[0] <= wr_pay;
                for (int unsigned i = 1; i < STALL_CYCLES; i++) begin
                    v_q[i] <= v_q[i-1];
                    p_q[i] <= p_q[i-1];
                end
            end
        end
        assign wr_v = v_q[STALL_CYCLES-1];
        assign wr_p = p_q[STALL_CYCLES-1];
    end

    assign wr_en   = wr_v;
    assign wr_addr = wr_p[P_W-1:1];

    // ---------------- read side ----------------
    rb_raster_ctr #(.CW(C_W), .RW(H_W)) u_read_ctr (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr),
        .adv_i      (rd_hs),
        .width_i    (w_q),
        .row_max_i  (h_q - H_W'(KERNEL)),
        .col_o      (rcol),
        .row_o      (rrow),
        .col_last_o (rcol_last),
        .last_o     (r_last)
    );

    assign rd_valid = run && ({1'b0, rows_wr_q} >= {1'b0, rrow} + (H_W+1)'(KERNEL));
    assign rd_hs    = rd_valid && rd_ready;
    assign rd_last  = rd_valid && r_last;
    assign rd_col   = rcol;

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            rows_wr_q <= '0;
            rows_rd_q <= '0;
            rline_q   <= '0;
        end else begin
            if (wr_v && wr_p[0]) rows_wr_q <= rows_wr_q + H_W'(1);
            if (rd_hs && rcol_last) begin
                rows_rd_q <= rows_rd_q + H_W'(1);
                rline_q   <= L_W'(line_inc(32'(rline_q), RB_COUNT));
            end
        end
    end

    always_comb begin
        int unsigned tap;
        rd_lines = '0;
        tap      = 32'(rline_q);
        for (int unsigned k = 0; k < KERNEL; k++) begin
            rd_lines[k*L_W +: L_W] = run ? L_W'(tap) : '0;
            tap = line_inc(tap, RB_COUNT);
        end
    end

endmodule

// File: tb/tb_rb_window_agu.sv
// Directed testbench for rb_window_agu (W=8, H=5, KERNEL=3, RB_COUNT=4, 1 stall).
module tb_rb_window_agu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, abort, ext_ready, rd_ready;
    logic [10:0] cfg_width, cfg_height;
    logic        busy, done, cfg_err, ext_valid, wr_en, rd_valid, rd_last;
    logic [19:0] ext_addr;
    logic [11:0] wr_addr;
    logic [9:0]  rd_col;
    logic [5:0]  rd_lines;

    int checks   = 0;
    int failures = 0;

    int nfetch, addr_err, stab_err, nwr, wr_t_err, wr_a_err, row4_cnt;
    int nrd, rd_err, nlast, last_err, ndone, done_busy_err, first_rd, wr27;
    bit timeout;

    rb_window_agu #(
        .MAX_WIDTH(1024), .MAX_HEIGHT(1024), .RB_COUNT(4), .KERNEL(3), .STALL_CYCLES(1)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .ext_addr(ext_addr), .ext_valid(ext_valid), .ext_ready(ext_ready),
        .wr_addr(wr_addr), .wr_en(wr_en),
        .rd_col(rd_col), .rd_lines(rd_lines), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_last(rd_last)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int w, input int h);
        cfg_width  = 11'(w);
        cfg_height = 11'(h);
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    // Runs one frame from the cycle after start, gathering statistics against
    // an address-arithmetic reference model.
    task automatic run_frame(input int w, input int h, input bit rnd);
        int total;
        bit prev_hs, prev_stall;
        int prev_a, post;
        logic [19:0] stall_a;
        total = w * (h - 2);
        prev_hs = 0; prev_stall = 0; prev_a = 0; post = -1; stall_a = '0;
        nfetch = 0; addr_err = 0; stab_err = 0; nwr = 0; wr_t_err = 0; wr_a_err = 0;
        row4_cnt = 0; nrd = 0; rd_err = 0; nlast = 0; last_err = 0; ndone = 0;
        done_busy_err = 0; first_rd = -1; wr27 = -1; timeout = 1;
        for (int c = 0; c < 3000; c++) begin
            ext_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            rd_ready  = 1'b1;
            if (wr_en !== prev_hs) wr_t_err++;
            if (wr_en === 1'b1) begin
                nwr++;
                if (wr_addr !== 12'(((prev_a / w) % 4) * 1024 + prev_a % w)) wr_a_err++;
                if (prev_a >= 4*w && prev_a < 5*w && wr_addr[11:10] == 2'd0) row4_cnt++;
                if (wr_addr === 12'(2*1024 + w - 1) && wr27 < 0) wr27 = c;
            end
            if (prev_stall && (ext_valid !== 1'b1 || ext_addr !== stall_a)) stab_err++;
            prev_hs = (ext_valid === 1'b1) && ext_ready;
            if (prev_hs) begin
                if (ext_addr !== 20'(nfetch)) addr_err++;
                prev_a = int'(ext_addr);
                nfetch++;
            end
            prev_stall = (ext_valid === 1'b1) && !ext_ready;
            stall_a    = ext_addr;
            if (rd_valid === 1'b1 && first_rd < 0) first_rd = c;
            if (rd_valid === 1'b1 && rd_ready) begin
                int ry;
                logic [5:0] el;
                ry = nrd / w;
                el = '0;
                for (int k = 0; k < 3; k++) el[2*k +: 2] = 2'((ry + k) % 4);
                if (rd_col !== 10'(nrd % w) || rd_lines !== el) rd_err++;
                if (rd_last !== (nrd == total - 1)) last_err++;
                if (rd_last === 1'b1) nlast++;
                nrd++;
            end
            if (done === 1'b1) begin
                ndone++;
                if (busy !== 1'b0) done_busy_err++;
                if (post < 0) post = c;
            end
            if (post >= 0 && c >= post + 3) begin
                timeout = 0;
                break;
            end
            step();
        end
        ext_ready = 1'b0;
        rd_ready  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; abort = 1'b0; ext_ready = 1'b0; rd_ready = 1'b0;
        cfg_width = '0; cfg_height = '0;
        step(); step();
        checks++; if ({busy, done, cfg_err, ext_valid, wr_en, rd_valid, rd_last, ext_addr, wr_addr, rd_col, rd_lines} !== '0) begin failures++; $display("FAIL reset_outputs busy=%b ext_valid=%b wr_en=%b rd_valid=%b ext_addr=%0d exp all 0", busy, ext_valid, wr_en, rd_valid, ext_addr); end
        rst = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle busy=%b exp 0", busy); end
    endtask

    task automatic test_free_run();
        do_start(8, 5);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL free_busy busy=%b exp 1", busy); end
        run_frame(8, 5, 1'b0);
        checks++; if (timeout) begin failures++; $display("FAIL free_timeout no done within budget"); end
        checks++; if (nfetch !== 40 || addr_err !== 0) begin failures++; $display("FAIL free_fetch count=%0d addr_err=%0d exp 40/0", nfetch, addr_err); end
        checks++; if (nwr !== 40 || wr_t_err !== 0) begin failures++; $display("FAIL free_wr count=%0d timing_err=%0d exp 40/0", nwr, wr_t_err); end
        checks++; if (wr_a_err !== 0 || row4_cnt !== 8) begin failures++; $display("FAIL free_wr_addr err=%0d row4_line0=%0d exp 0/8", wr_a_err, row4_cnt); end
        checks++; if (nrd !== 24 || rd_err !== 0) begin failures++; $display("FAIL free_reads count=%0d err=%0d exp 24/0", nrd, rd_err); end
        checks++; if (nlast !== 1 || last_err !== 0) begin failures++; $display("FAIL free_rd_last count=%0d err=%0d exp 1/0", nlast, last_err); end
        checks++; if (wr27 < 0 || first_rd !== wr27 + 1) begin failures++; $display("FAIL free_rd_valid_rise first=%0d wr27=%0d exp first=wr27+1", first_rd, wr27); end
        checks++; if (ndone !== 1 || done_busy_err !== 0) begin failures++; $display("FAIL free_done pulses=%0d busy_err=%0d exp 1/0", ndone, done_busy_err); end
    endtask

    task automatic test_backpressure();
        int nf, nr;
        bit seen;
        do_start(8, 5);
        ext_ready = 1'b1; rd_ready = 1'b0; nf = 0;
        for (int c = 0; c < 200; c++) begin
            if (ext_valid === 1'b1) nf++;
            step();
        end
        checks++; if (nf !== 32) begin failures++; $display("FAIL bp_fetch_count got=%0d exp 32", nf); end
        checks++; if (ext_valid !== 1'b0 || ext_addr !== 20'd32) begin failures++; $display("FAIL bp_stall ext_valid=%b ext_addr=%0d exp 0/32", ext_valid, ext_addr); end
        checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL bp_rd_valid got=%b exp 1", rd_valid); end
        rd_ready = 1'b1; nr = 0;
        for (int c = 0; c < 100 && nr < 8; c++) begin
            if (rd_valid === 1'b1) nr++;
            step();
        end
        rd_ready = 1'b0;
        checks++; if (nr !== 8) begin failures++; $display("FAIL bp_reads got=%0d exp 8", nr); end
        checks++; if (ext_valid !== 1'b1 || ext_addr !== 20'd32) begin failures++; $display("FAIL bp_resume ext_valid=%b ext_addr=%0d exp 1/32", ext_valid, ext_addr); end
        rd_ready = 1'b1; seen = 0;
        for (int c = 0; c < 1000; c++) begin
            if (done === 1'b1) begin seen = 1; break; end
            step();
        end
        checks++; if (!seen) begin failures++; $display("FAIL bp_done got=0 exp 1"); end
        ext_ready = 1'b0; rd_ready = 1'b0;
        step();
    endtask

    task automatic test_random_ready();
        do_start(8, 5);
        run_frame(8, 5, 1'b1);
        checks++; if (timeout) begin failures++; $display("FAIL rnd_timeout no done within budget"); end
        checks++; if (nfetch !== 40 || addr_err !== 0) begin failures++; $display("FAIL rnd_fetch count=%0d addr_err=%0d exp 40/0", nfetch, addr_err); end
        checks++; if (stab_err !== 0) begin failures++; $display("FAIL rnd_stable err=%0d exp 0", stab_err); end
        checks++; if (nwr !== 40 || wr_t_err !== 0 || wr_a_err !== 0) begin failures++; $display("FAIL rnd_wr count=%0d timing=%0d addr=%0d exp 40/0/0", nwr, wr_t_err, wr_a_err); end
        checks++; if (nrd !== 24 || rd_err !== 0 || ndone !== 1) begin failures++; $display("FAIL rnd_reads count=%0d err=%0d done=%0d exp 24/0/1", nrd, rd_err, ndone); end
    endtask

    task automatic test_abort();
        int nf, dn;
        do_start(8, 5);
        ext_ready = 1'b1; rd_ready = 1'b1; nf = 0;
        for (int c = 0; c < 100 && nf < 13; c++) begin
            if (ext_valid === 1'b1) nf++;
            step();
        end
        ext_ready = 1'b0; abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if ({ext_valid, rd_valid, wr_en, busy, done} !== 5'b0) begin failures++; $display("FAIL abort_outputs ev=%b rv=%b we=%b busy=%b done=%b exp 0", ext_valid, rd_valid, wr_en, busy, done); end
        dn = 0;
        for (int c = 0; c < 10; c++) begin
            if (done === 1'b1 || busy === 1'b1) dn++;
            step();
        end
        checks++; if (dn !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp 0", dn); end
        do_start(8, 5);
        run_frame(8, 5, 1'b0);
        checks++; if (nfetch !== 40 || addr_err !== 0 || nwr !== 40 || wr_a_err !== 0) begin failures++; $display("FAIL abort_refetch count=%0d err=%0d wr=%0d wr_err=%0d exp 40/0/40/0", nfetch, addr_err, nwr, wr_a_err); end
        checks++; if (nrd !== 24 || rd_err !== 0 || ndone !== 1) begin failures++; $display("FAIL abort_reframe reads=%0d err=%0d done=%0d exp 24/0/1", nrd, rd_err, ndone); end
    endtask

    task automatic test_cfg_err();
        int ws[2];
        int hs[2];
        ws = '{8, 0};
        hs = '{2, 5};
        for (int i = 0; i < 2; i++) begin
            do_start(ws[i], hs[i]);
            checks++; if (cfg_err !== 1'b1 || busy !== 1'b0 || ext_valid !== 1'b0) begin failures++; $display("FAIL cfg_err_pulse%0d cfg_err=%b busy=%b ev=%b exp 1/0/0", i, cfg_err, busy, ext_valid); end
            step();
            checks++; if (cfg_err !== 1'b0 || busy !== 1'b0 || ext_valid !== 1'b0) begin failures++; $display("FAIL cfg_err_clear%0d cfg_err=%b busy=%b ev=%b exp 0/0/0", i, cfg_err, busy, ext_valid); end
        end
    endtask

    task automatic test_reset_mid_frame();
        do_start(8, 5);
        ext_ready = 1'b1; rd_ready = 1'b1;
        for (int c = 0; c < 30; c++) step();
        rst = 1'b0;
        step();
        checks++; if ({busy, done, cfg_err, ext_valid, wr_en, rd_valid, rd_last, ext_addr, wr_addr, rd_col, rd_lines} !== '0) begin failures++; $display("FAIL rst_mid_outputs busy=%b ev=%b we=%b rv=%b ext_addr=%0d wr_addr=%0d exp all 0", busy, ext_valid, wr_en, rd_valid, ext_addr, wr_addr); end
        rst = 1'b1; ext_ready = 1'b0; rd_ready = 1'b0;
        step();
        do_start(4, 3);
        run_frame(4, 3, 1'b0);
        checks++; if (nrd !== 4 || rd_err !== 0) begin failures++; $display("FAIL rst_small_reads count=%0d err=%0d exp 4/0", nrd, rd_err); end
        checks++; if (nlast !== 1 || last_err !== 0) begin failures++; $display("FAIL rst_small_last count=%0d err=%0d exp 1/0", nlast, last_err); end
        checks++; if (ndone !== 1 || nfetch !== 12) begin failures++; $display("FAIL rst_small_done done=%0d fetches=%0d exp 1/12", ndone, nfetch); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_backpressure();
        test_random_ready();
        test_abort();
        test_cfg_err();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
